noc_eject_buffer: RTL and testbench
===================================

NOC_EJECT_BUFFER -- requirements
Module: noc_eject_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the flit depth of each per-VC FIFO (power of two, >=2).
REQ-002 Parameter NUM_VC, default 2, SHALL set the VC count; only 2 is supported.
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_  in  1  reset, asynchronous and active-low.
REQ-005 idata  in  35  flit from the upstream router output port.
REQ-006 ivalid  in  1  flit present this cycle.
REQ-007 ivch  in  1  VC of the incoming flit.
REQ-008 oack  out  2  per-VC credit return; connects to the router's iack.
REQ-009 olck  out  2  per-VC lock (packet in progress); connects to the router's ilck.
REQ-010 odata  out  35  flit to the local sink.
REQ-011 ovalid  out  1  odata is valid.
REQ-012 ovch  out  1  VC of odata.
REQ-013 iready  in  1  sink accepts the flit when ovalid is also 1.
REQ-014 err_ovf  out  1  sticky overflow flag.

Function
REQ-015 Flit type SHALL be idata[34:33]: 00 body, 01 head, 10 tail, 11 head+tail; bits [31:0] are payload and bit 32 is reserved.
REQ-016 When ivalid=1, the flit SHALL be written to the FIFO selected by ivch on the same edge.
REQ-017 FIFOs SHALL be registered, with no fall-through: a flit written at edge N SHALL be visible on odata no earlier than the cycle after edge N.
REQ-018 ovalid SHALL be 1 when the currently selected VC is non-empty; odata and ovch SHALL be driven combinationally from that FIFO's head.
REQ-019 Arbitration SHALL be round-robin per flit: after a transfer (ovalid and iready both 1) on VC v, priority SHALL move to the other VC; if only one VC is non-empty, that VC SHALL be selected.
REQ-020 While ovalid=1 and iready=0, odata and ovch SHALL be held stable.
REQ-021 oack[v] SHALL be registered and SHALL pulse high for one cycle, on the cycle after each dequeue from VC v.
REQ-022 olck[v] SHALL be set on the edge that writes a head (01) flit to VC v, and SHALL be cleared on the edge that dequeues a tail (10) flit from VC v.
REQ-023 A head+tail (11) flit SHALL leave olck unchanged.
REQ-024 If a tail dequeue and a head write on the same VC occur on the same edge, olck SHALL end up set.
REQ-025 A write to a full FIFO SHALL be accepted if that same FIFO is dequeued on the same edge.
REQ-026 A write to a full FIFO that is not dequeued on the same edge SHALL be dropped, and err_ovf SHALL be set until reset.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with DEPTH+1 states so that full and empty are distinct.

Reset
REQ-028 While rst_=0: FIFOs empty, round-robin priority on VC0, oack=00, olck=00, err_ovf=0, ovalid=0, odata=0, ovch=0.
REQ-029 Assertion of rst_ in mid-packet SHALL discard all buffered flits and SHALL generate no oack pulses.

Structure
REQ-030 Flit width (35), type-field position and encodings, and NUM_VC SHALL live in the shared package noc_pkg.
REQ-031 The per-VC storage SHALL be a sub-module noc_vc_fifo (write, read, full, empty, head flit), instantiated NUM_VC times.

Verification
REQ-032 Reset: hold rst_=0 with random inputs -> every output is 0; on release, olck=00 and oack=00.
REQ-033 Single flit: one 11-type flit on VC0, payload 0xDEADBEEF, at edge 1 with iready=1 -> ovalid=1, ovch=0 in cycle 2; oack=01 in cycle 3 only; olck stays 00.
REQ-034 Packet lock: head, body, tail flits on VC1 with iready=0 -> olck=10 after the head edge; raise iready -> olck=00 in the cycle after the tail dequeue, and exactly three oack[1] pulses.
REQ-035 Overflow: iready=0, write 5 flits on VC0 -> the 5th flit is dropped, err_ovf=1, the FIFO still holds flits 1-4 in order.
REQ-036 Full with simultaneous read: VC0 full, iready=1 and a write on the same edge -> flit accepted, err_ovf stays 0.
REQ-037 Fairness: both VCs loaded with 3 flits each, iready=1 -> ovch sequence 0,1,0,1,0,1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC ejection definitions: flit layout, flit type encodings and VC count.
// Flit = {type[1:0], reserved, payload[31:0]}.
package noc_pkg;

  localparam int FLIT_W    = 35;
  localparam int PAYLOAD_W = 32;
  localparam int TYPE_HI   = 34;
  localparam int TYPE_LO   = 33;
  localparam int RSVD_BIT  = 32;
  localparam int NUM_VC    = 2;

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10,
    FT_HT   = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e             ftype;
    logic                   rsvd;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Per-VC registered flit FIFO: write visible one cycle later, head shown combinationally.
// A write while full is only taken when the same edge also reads; otherwise the caller drops it.
module noc_vc_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head_dat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_rd;
  logic              do_wr;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_en && (!full || do_rd);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/noc_eject_buffer.sv
// Ejection buffer: per-VC FIFOs, round-robin per-flit output, credit (oack) and packet lock (olck).
// Output appears the cycle after the write; a stalled output holds its VC and flit until accepted.
module noc_eject_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_VC = noc_pkg::NUM_VC
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [FLIT_W-1:0] idata,
  input  logic              ivalid,
  input  logic              ivch,
  output logic [NUM_VC-1:0] oack,
  output logic [NUM_VC-1:0] olck,
  output logic [FLIT_W-1:0] odata,
  output logic              ovalid,
  output logic              ovch,
  input  logic              iready,
  output logic              err_ovf
);

  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] wr_ok;
  logic [NUM_VC-1:0] drop;
  logic [NUM_VC-1:0] rd_en;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] head_wr;
  logic [NUM_VC-1:0] tail_deq;
  logic [FLIT_W-1:0] head_dat [NUM_VC];

  logic       prio;
  logic       hold_vld;
  logic       hold_vc;
  logic       rr_sel;
  logic       sel;
  logic       xfer;
  flit_type_e in_type;

  assign in_type = flit_type_e'(idata[TYPE_HI:TYPE_LO]);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_en[v]    = ivalid && (ivch == 1'(v));
    assign wr_ok[v]    = wr_en[v] && (!full[v] || rd_en[v]);
    assign drop[v]     = wr_en[v] && full[v] && !rd_en[v];
    assign head_wr[v]  = wr_ok[v] && (in_type == FT_HEAD);
    assign tail_deq[v] = rd_en[v] &&
                         (flit_type_e'(head_dat[v][TYPE_HI:TYPE_LO]) == FT_TAIL);

    noc_vc_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_     (rst_),
      .wr_en    (wr_en[v]),
      .wr_dat   (idata),
      .rd_en    (rd_en[v]),
      .full     (full[v]),
      .empty    (empty[v]),
      .head_dat (head_dat[v])
    );
  end

  // A stalled offer keeps its VC so odata/ovch cannot move under backpressure.
  always_comb begin
    rr_sel = prio;
    if (empty[prio]) rr_sel = ~prio;
    sel    = hold_vld ? hold_vc : rr_sel;
    ovalid = !empty[sel];
    xfer   = ovalid && iready;
    rd_en  = '0;
    if (xfer) rd_en[sel] = 1'b1;
    odata  = ovalid ? head_dat[sel] : '0;
    ovch   = ovalid ? sel : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prio     <= 1'b0;
      hold_vld <= 1'b0;
      hold_vc  <= 1'b0;
      oack     <= '0;
      olck     <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (xfer) prio <= ~sel;
      hold_vld <= ovalid && !iready;
      hold_vc  <= sel;
      oack     <= rd_en;
      // Head set wins over a same-edge tail clear.
      olck     <= (olck & ~tail_deq) | head_wr;
      if (|drop) err_ovf <= 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_)
                   (ovalid && !iready) |=> (ovalid && $stable(odata) && $stable(ovch)));

endmodule

// File: tb/tb_noc_eject_buffer.sv
// Self-checking bench for noc_eject_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_noc_eject_buffer;
  import noc_pkg::*;

  localparam int DEPTH = 4;

  logic              clk;
  logic              rst_;
  logic [FLIT_W-1:0] idata;
  logic              ivalid;
  logic              ivch;
  logic [1:0]        oack;
  logic [1:0]        olck;
  logic [FLIT_W-1:0] odata;
  logic              ovalid;
  logic              ovch;
  logic              iready;
  logic              err_ovf;

  int checks   = 0;
  int failures = 0;

  noc_eject_buffer #(.DEPTH(DEPTH), .NUM_VC(2)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .idata   (idata),
    .ivalid  (ivalid),
    .ivch    (ivch),
    .oack    (oack),
    .olck    (olck),
    .odata   (odata),
    .ovalid  (ovalid),
    .ovch    (ovch),
    .iready  (iready),
    .err_ovf (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two plain queues plus arbitration/lock/credit state.
  logic [FLIT_W-1:0] mq0 [$];
  logic [FLIT_W-1:0] mq1 [$];
  int                m_prio;
  logic              m_hold;
  int                m_hold_vc;
  logic [1:0]        m_olck;
  logic [1:0]        m_oack;
  logic              m_err;

  function automatic int qsize(int v);
    return (v == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [FLIT_W-1:0] qfront(int v);
    return (v == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic logic [FLIT_W-1:0] qpop(int v);
    if (v == 0) return mq0.pop_front();
    return mq1.pop_front();
  endfunction

  function automatic void qpush(int v, logic [FLIT_W-1:0] d);
    if (v == 0) mq0.push_back(d);
    else        mq1.push_back(d);
  endfunction

  function automatic int msel();
    if (m_hold) return m_hold_vc;
    if (qsize(m_prio) != 0) return m_prio;
    return 1 - m_prio;
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_prio    = 0;
    m_hold    = 1'b0;
    m_hold_vc = 0;
    m_olck    = 2'b00;
    m_oack    = 2'b00;
    m_err     = 1'b0;
  endtask

  task automatic model_step();
    int                s;
    int                wv;
    logic              ov;
    logic              x;
    logic [1:0]        deq;
    logic [1:0]        td;
    logic [1:0]        hw;
    logic [FLIT_W-1:0] f;
    if (!rst_) begin
      model_reset();
      return;
    end
    s   = msel();
    ov  = (qsize(s) != 0);
    x   = ov && iready;
    deq = 2'b00;
    td  = 2'b00;
    hw  = 2'b00;
    if (x) begin
      f      = qpop(s);
      deq[s] = 1'b1;
      td[s]  = (f[34:33] == 2'b10);
    end
    if (ivalid) begin
      wv = int'(ivch);
      if (qsize(wv) < DEPTH) begin
        qpush(wv, idata);
        hw[wv] = (idata[34:33] == 2'b01);
      end else begin
        m_err = 1'b1;
      end
    end
    m_olck    = (m_olck & ~td) | hw;
    m_oack    = deq;
    m_hold    = ov && !iready;
    m_hold_vc = s;
    if (x) m_prio = 1 - s;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  int   c_sel;
  logic c_ov;
  always @(negedge clk) begin
    c_sel = msel();
    c_ov  = (qsize(c_sel) != 0);
    chk("m_ovalid", 64'(ovalid), 64'(c_ov));
    if (c_ov) begin
      chk("m_odata", 64'(odata), 64'(qfront(c_sel)));
      chk("m_ovch",  64'(ovch),  64'(c_sel));
    end else if (!rst_) begin
      chk("m_odata_rst", 64'(odata), 64'd0);
      chk("m_ovch_rst",  64'(ovch),  64'd0);
    end
    chk("m_oack",    64'(oack),    64'(m_oack));
    chk("m_olck",    64'(olck),    64'(m_olck));
    chk("m_err_ovf", 64'(err_ovf), 64'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic put(input logic v, input logic ch, input logic [1:0] ty, input logic [31:0] pl);
    flit_t f;
    f.ftype   = flit_type_e'(ty);
    f.rsvd    = 1'b0;
    f.payload = pl;
    idata     = f;
    ivalid    = v;
    ivch      = ch;
  endtask

  task automatic rand_inputs();
    ivalid = ($urandom_range(0, 9) < 6);
    ivch   = 1'($urandom_range(0, 1));
    idata  = 35'({3'($urandom_range(0, 7)), $urandom});
    iready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic do_reset();
    #2;
    rst_ = 1'b0;
    model_reset();
    ivalid = 1'b0;
    iready = 1'b0;
    tick();
    tick();
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  int pulses;

  initial begin
    rst_   = 1'b0;
    ivalid = 1'b0;
    ivch   = 1'b0;
    idata  = '0;
    iready = 1'b0;
    model_reset();

    // Reset held with random inputs: all outputs zero.
    for (int i = 0; i < 4; i++) begin
      tick();
      rand_inputs();
    end
    @(negedge clk);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_odata",  64'(odata),  64'd0);
    chk("rst_ovch",   64'(ovch),   64'd0);
    chk("rst_oack",   64'(oack),   64'd0);
    chk("rst_olck",   64'(olck),   64'd0);
    chk("rst_err",    64'(err_ovf), 64'd0);
    tick();
    rst_   = 1'b1;
    ivalid = 1'b0;
    iready = 1'b0;
    tick();
    @(negedge clk);
    chk("rel_olck", 64'(olck), 64'd0);
    chk("rel_oack", 64'(oack), 64'd0);

    // Single head+tail flit on VC0.
    put(1'b1, 1'b0, 2'b11, 32'hDEADBEEF);
    iready = 1'b1;
    tick();
    ivalid = 1'b0;
    @(negedge clk);
    chk("sf_ovalid", 64'(ovalid), 64'd1);
    chk("sf_ovch",   64'(ovch),   64'd0);
    chk("sf_odata",  64'(odata),  64'h6DEADBEEF);
    chk("sf_oack0",  64'(oack),   64'd0);
    tick();
    @(negedge clk);
    chk("sf_oack1",  64'(oack),   64'h1);
    chk("sf_empty",  64'(ovalid), 64'd0);
    tick();
    @(negedge clk);
    chk("sf_oack2",  64'(oack),   64'd0);
    chk("sf_olck",   64'(olck),   64'd0);

    // Head/body/tail on VC1 under backpressure, then drain.
    iready = 1'b0;
    put(1'b1, 1'b1, 2'b01, 32'h100);
    tick();
    put(1'b1, 1'b1, 2'b00, 32'h101);
    @(negedge clk);
    chk("pk_lock_head", 64'(olck), 64'h2);
    tick();
    put(1'b1, 1'b1, 2'b10, 32'h102);
    tick();
    ivalid = 1'b0;
    @(negedge clk);
    chk("pk_lock_held", 64'(olck), 64'h2);
    iready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      pulses += int'(oack[1]);
    end
    chk("pk_pulses", 64'(pulses), 64'd3);
    chk("pk_unlock", 64'(olck),   64'd0);

    // Overflow: fifth write to a stalled full VC0 is dropped.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      put(1'b1, 1'b0, 2'b00, 32'(k));
      tick();
    end
    ivalid = 1'b0;
    @(negedge clk);
    chk("ovf_err", 64'(err_ovf), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_order", 64'(odata[31:0]), 64'(k));
      iready = 1'b1;
      tick();
      @(negedge clk);
    end
    chk("ovf_drained", 64'(ovalid), 64'd0);

    // Full FIFO written on the same edge it is read.
    do_reset();
    for (int k = 10; k <= 13; k++) begin
      put(1'b1, 1'b0, 2'b00, 32'(k));
      tick();
    end
    ivalid = 1'b0;
    @(negedge clk);
    chk("fr_head", 64'(odata[31:0]), 64'd10);
    iready = 1'b1;
    put(1'b1, 1'b0, 2'b00, 32'd14);
    tick();
    ivalid = 1'b0;
    @(negedge clk);
    chk("fr_err", 64'(err_ovf), 64'd0);
    for (int k = 11; k <= 14; k++) begin
      chk("fr_order", 64'(odata[31:0]), 64'(k));
      tick();
      @(negedge clk);
    end
    chk("fr_err_end", 64'(err_ovf), 64'd0);

    // Fairness: 3 flits per VC, alternating service.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      put(1'b1, (k < 3) ? 1'b0 : 1'b1, 2'b00, 32'(20 + k));
      tick();
    end
    ivalid = 1'b0;
    @(negedge clk);
    iready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("fair_ovalid", 64'(ovalid), 64'd1);
      chk("fair_ovch",   64'(ovch),   64'(i % 2));
      tick();
      @(negedge clk);
    end

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 399) == 0) begin
        rst_ = 1'b0;
        model_reset();
      end else begin
        rst_ = 1'b1;
      end
      tick();
    end
    rst_   = 1'b1;
    ivalid = 1'b0;
    iready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
